// File: rtl/phy_rx_align.sv
// phy_rx_align -- serial receiver that finds byte alignment on COMMA
// training symbols, then assembles 32-bit words.
//
// Ports:
//   clk_32f         : bit clock, one serial bit sampled per rising edge
//   reset           : asynchronous, active-high
//   serial_in       : serial line, MSB-first bytes, byte 3 of a word first
//   data_out        : last received word (registered, held between words)
//   valid_out       : data_out is a data word (0 for an all-COMMA idle word)
//   sincronizar_bus : receiver is byte- and word-aligned (sticky until reset)
//
// Lock is reached after SYNC_COUNT consecutive byte-aligned COMMAs. The
// transmitter trains with whole idle words, so the lock edge is also a word
// boundary and no further re-alignment is ever attempted.
module phy_rx_align #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        serial_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        sincronizar_bus
);

  localparam int CW = (SYNC_COUNT < 2) ? 1 : $clog2(SYNC_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, ALIGN, SYNC} state_t;

  state_t        state, state_nxt;
  // Only the previous 7 bits are stored; the 8th bit of the compared byte
  // is serial_in itself, so matches are seen on the sampling edge.
  logic [6:0]    window;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [CW-1:0] comma_cnt;
  logic [23:0]   word_acc;   // bytes 3..1 of the word being assembled
  logic [7:0]    cur_byte;
  logic [31:0]   cur_word;
  logic          is_comma;
  logic          byte_end;
  logic          lock;

  assign cur_byte = {window, serial_in};
  assign cur_word = {word_acc, cur_byte};
  assign is_comma = (cur_byte == COMMA);
  assign byte_end = (bit_cnt == 3'd7);

  // State register
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    lock      = 1'b0;
    case (state)
      SEARCH: begin
        if (is_comma) begin
          if (SYNC_COUNT <= 1) begin
            state_nxt = SYNC;
            lock      = 1'b1;
          end else begin
            state_nxt = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (byte_end) begin
          if (!is_comma) begin
            state_nxt = SEARCH;
          end else if (int'(comma_cnt) + 1 >= SYNC_COUNT) begin
            state_nxt = SYNC;
            lock      = 1'b1;
          end
        end
      end
      SYNC:    state_nxt = SYNC;
      default: state_nxt = SEARCH;
    endcase
  end

  // Datapath: window, counters, word assembly, outputs
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      window          <= '0;
      bit_cnt         <= '0;
      byte_cnt        <= '0;
      comma_cnt       <= '0;
      word_acc        <= '0;
      data_out        <= '0;
      valid_out       <= 1'b0;
      sincronizar_bus <= 1'b0;
    end else begin
      window          <= cur_byte[6:0];
      sincronizar_bus <= (state_nxt == SYNC);
      case (state)
        SEARCH: begin
          // A match here fixes the byte boundary: next bit is bit 0.
          bit_cnt   <= '0;
          byte_cnt  <= '0;
          comma_cnt <= is_comma ? CW'(1) : '0;
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_end) comma_cnt <= is_comma ? comma_cnt + CW'(1) : '0;
          if (lock)     byte_cnt  <= '0;
        end
        SYNC: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_end) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_acc <= {word_acc[15:0], cur_byte};
            if (byte_cnt == 2'd3) begin
              data_out  <= cur_word;
              // An all-COMMA word is idle by definition, even if it was
              // meant as data.
              valid_out <= (cur_word != {4{COMMA}});
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/phy_rx_align.md
PHY_RX_ALIGN -- requirements
Module: phy_rx_align

Interface
REQ-001 The block SHALL expose parameter COMMA, default 8'hBC, the idle/training symbol byte.
REQ-002 The block SHALL expose parameter SYNC_COUNT, default 4, the number of consecutive aligned COMMA bytes required for lock.
REQ-003 Port clk_32f, input, 1 bit: the single clock, one serial bit per rising edge; all state SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port serial_in, input, 1 bit: serial line, MSB-first bytes, MSB-first words (byte 3 first).
REQ-006 Port data_out, output, 32 bits: last received word, registered.
REQ-007 Port valid_out, output, 1 bit: data_out holds a data word (not an idle word).
REQ-008 Port sincronizar_bus, output, 1 bit: receiver is byte- and word-aligned.

Function
REQ-009 Incoming bits SHALL be shifted into an 8-bit window, new bit at LSB; byte compare uses {window[6:0], serial_in} on the sampling edge.
REQ-010 FSM states SHALL be SEARCH, ALIGN and SYNC; reset state SEARCH.
REQ-011 SEARCH: every edge, if the compared byte equals COMMA, go to ALIGN, set comma count = 1, clear bit counter to 0 (byte boundary fixed there); else stay.
REQ-012 ALIGN: bit counter 0..7 wraps every 8 bits; at each byte boundary, COMMA increments the count, non-COMMA returns to SEARCH with count cleared.
REQ-013 ALIGN: on the edge where the count reaches SYNC_COUNT, go to SYNC and assert sincronizar_bus on that same edge; byte counter cleared so the next byte is word byte 3.
REQ-014 SYNC: bytes SHALL be assembled into a 32-bit word, byte 3 in data_out[31:24] through byte 0 in [7:0].
REQ-015 On the edge sampling the 32nd bit of a word, the word SHALL be written to data_out; valid_out = 0 if all four bytes equal COMMA, else 1.
REQ-016 data_out and valid_out SHALL hold their values for the 31 edges between word updates.
REQ-017 An all-COMMA idle word SHALL still update data_out (to {4{COMMA}}) with valid_out = 0.
REQ-018 A data word equal to {4{COMMA}} is unrepresentable; the transmitter never sends it, and the receiver SHALL treat it as idle.
REQ-019 The transmitter sends training as whole idle words, so the lock edge (end of the SYNC_COUNT-th COMMA) is a word boundary; the block SHALL NOT re-align after lock.
REQ-020 Once in SYNC, the block SHALL remain in SYNC until reset; COMMA bytes inside data words SHALL NOT disturb alignment.
REQ-021 In SEARCH/ALIGN, valid_out SHALL be 0 and data_out SHALL hold its last value.
REQ-022 Bit and byte counters SHALL wrap modulo 8 and modulo 4 without extra cycles.

Reset
REQ-023 reset = 1 SHALL immediately, independent of clk_32f, force state SEARCH, window = 0, all counters = 0, data_out = 32'h0, valid_out = 0, sincronizar_bus = 0.
REQ-024 Reset asserted mid-word or mid-training SHALL discard partial bytes; after release, alignment restarts from SEARCH with the next sampled bit.
REQ-025 The first sampling edge after reset deassertion SHALL be treated as an ordinary bit.

Verification
REQ-026 Send 3 random bits, then 4 aligned 8'hBC bytes -> sincronizar_bus rises on the edge sampling the last bit of the 4th BC; valid_out stays 0.
REQ-027 After lock, send 32'hDEADBEEF MSB-first -> on the 32nd bit edge data_out = 32'hDEADBEEF, valid_out = 1, held for 31 edges.
REQ-028 After lock, send BC,BC,BC,BC -> data_out = 32'hBCBCBCBC, valid_out = 0; then 32'h00BC00BC -> valid_out = 1, sincronizar_bus stays 1.
REQ-029 Training BC,BC,BC,8'h55,BC,BC,BC,BC -> returns to SEARCH after 8'h55; lock occurs only at the end of the second group of 4.
REQ-030 Assert reset for 3 ns asynchronously mid-word while locked -> all outputs 0 before the next edge; re-training of 4 BC re-locks.
REQ-031 Back-to-back words 32'h01234567, 32'h89ABCDEF -> two updates exactly 32 edges apart with the correct values and no lost bits.
